amm_onchip_ram_pipelined: RTL
=============================

AMM_ONCHIP_RAM_PIPELINED -- requirements
Module: amm_onchip_ram_pipelined

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32: data width in bits, a multiple of 8.
REQ-002 The block SHALL take parameter ADDR_W, default 10: word address width; depth is 2**ADDR_W words.
REQ-003 The block SHALL take parameter READ_LATENCY, default 1: cycles from read acceptance to readdatavalid; legal values are 1, 2 and 3.
REQ-004 The block SHALL take parameter CLEAR_ON_RESET, default 1: when 1, all words are zeroed after reset.
REQ-005 The block SHALL have one clock, port clk, input, 1 bit, with all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-007 The block SHALL have port reset_req, input, 1 bit: when high, all transaction acceptance is blocked.
REQ-008 The block SHALL have port clken, input, 1 bit: when low, acceptance and clear progress are blocked.
REQ-009 The block SHALL have ports chipselect, read and write, each input, 1 bit: Avalon-MM slave strobes.
REQ-010 The block SHALL have port address, input, ADDR_W bits: word address.
REQ-011 The block SHALL have port byteenable, input, DATA_W/8 bits: write lane enables.
REQ-012 The block SHALL have port writedata, input, DATA_W bits.
REQ-013 The block SHALL have port readdata, output, DATA_W bits.
REQ-014 The block SHALL have port readdatavalid, output, 1 bit: one pulse per accepted read.
REQ-015 The block SHALL have port waitrequest, output, 1 bit: stall signal to the master.
REQ-016 The block SHALL have port clearing, output, 1 bit: high while the clear sequence runs.

Function
REQ-017 waitrequest SHALL equal reset OR clearing OR NOT clken OR reset_req, combinationally.
REQ-018 A transaction SHALL be accepted on a cycle with chipselect=1, read or write=1, and waitrequest=0.
REQ-019 An accepted write SHALL update only the byte lanes whose byteenable bit is 1, taking effect at that clock edge.
REQ-020 When read and write are both high on an accepted cycle, the block SHALL perform only the write and produce no readdatavalid.
REQ-021 For a read accepted at edge N, readdatavalid SHALL be 1 for exactly the cycle after edge N+READ_LATENCY-1, with readdata holding the word at the accepted address.
REQ-022 A read accepted one cycle after a write to the same address SHALL return the newly written data.
REQ-023 Reads SHALL be fully pipelined: back-to-back accepted reads SHALL give back-to-back readdatavalid pulses, in order.
REQ-024 The read pipeline SHALL advance every cycle regardless of clken and reset_req, so reads already in flight still complete.
REQ-025 readdata SHALL hold its last value while readdatavalid=0.
REQ-026 The state machine SHALL have two states, CLEAR and RUN.
REQ-027 In CLEAR, a clear counter SHALL write all-zero data to address counter on each cycle with clken=1 and reset_req=0, then increment.
REQ-028 When the counter reaches 2**ADDR_W-1 and that write completes, the state SHALL go to RUN.
REQ-029 The clearing output SHALL be 1 exactly while the state is CLEAR.
REQ-030 With CLEAR_ON_RESET=0, the state SHALL be RUN on the first cycle after reset deasserts.
REQ-031 A master access presented during CLEAR SHALL be stalled by waitrequest and not lost.

Reset
REQ-032 On a clk edge with reset=1, the block SHALL clear readdatavalid to 0 and readdata to 0.
REQ-033 On a clk edge with reset=1, the block SHALL discard all in-flight reads.
REQ-034 On a clk edge with reset=1, the block SHALL set the clear counter to 0.
REQ-035 On a clk edge with reset=1, the block SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-036 Reset asserted during CLEAR SHALL restart the clear sequence from address 0.
REQ-037 Reset asserted while a read is in flight SHALL suppress its readdatavalid.
REQ-038 Memory contents SHALL NOT be altered by reset itself; only the clear sequence alters them.

Verification
REQ-039 The bench SHALL cover: defaults, reset released, clken=1 -> clearing=1 and waitrequest=1 for exactly 1024 cycles, then reading address 0x3FF returns 0x00000000.
REQ-040 The bench SHALL cover: write 0xDEADBEEF to address 5 with byteenable=0xF, then write 0x11223344 to address 5 with byteenable=0x5, then read address 5 -> readdata=0xDE22BE44.
REQ-041 The bench SHALL cover: READ_LATENCY=3 with four back-to-back reads of addresses 1 to 4 -> four consecutive readdatavalid pulses, the first 3 cycles after the first acceptance, with data in address order.
REQ-042 The bench SHALL cover: clken=0 for 10 cycles in the middle of CLEAR -> the counter freezes, and clearing lasts 1034 cycles in total.
REQ-043 The bench SHALL cover: reset pulsed 2 cycles after a read is accepted with READ_LATENCY=3 -> no readdatavalid, and readdata=0.
REQ-044 The bench SHALL cover: read and write together to address 7 with data 0xA5A5A5A5 -> no readdatavalid, and a later read of address 7 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/amm_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM slave with byte enables, a fixed-latency pipelined read
// path and an optional zero-fill sequence that runs after reset.
module amm_onchip_ram_pipelined #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  clearing
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                access_c;
    logic                wr_accept_c;
    logic                rd_accept_c;
    logic                clr_we_c;

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];

    assign clearing    = (state_q == ST_CLEAR);
    assign waitrequest = reset | clearing | ~clken | reset_req;

    // A simultaneous read+write is treated as a write only.
    assign access_c    = chipselect & ~waitrequest;
    assign wr_accept_c = access_c & write;
    assign rd_accept_c = access_c & read & ~write;
    assign clr_we_c    = clearing & clken & ~reset_req & ~reset;

    // State and clear-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear sequencing: advance only on cycles that actually write a zero word
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clr_we_c) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // Storage array; deliberately not reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_accept_c) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Read delay line; data stages only load behind a valid so the output holds
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_accept_c;
            if (rd_accept_c) begin
                dat_q[0] <= mem[address];
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule
